timer_load_ctrl: RTL and testbench
==================================

TIMER_LOAD_CTRL -- requirements
Module: timer_load_ctrl

Interface
REQ-001 Parameter DONE_CYCLES, default 8: number of clk cycles the done output stays high.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 clearn  input  1  asynchronous, active-low reset.
REQ-004 key_valid  input  1  one-cycle strobe, key_code valid.
REQ-005 key_code  input  4  keypad code; 0-9 are digits, 10-15 are ignored.
REQ-006 start  input  1  one-cycle start/resume pulse.
REQ-007 stop  input  1  one-cycle stop/cancel pulse.
REQ-008 door_closed  input  1  level; 1 = door closed.
REQ-009 tick  input  1  one-cycle 1 Hz enable pulse.
REQ-010 zero  input  1  level from the down-counter chain; 1 = all digits at 0.
REQ-011 digits  output  12  BCD entry value {hundreds, tens, units}; load data for the counter chain.
REQ-012 load  output  1  one-cycle parallel-load strobe to the counter chain.
REQ-013 en  output  1  count enable to the counter chain.
REQ-014 heat_on  output  1  high while the timer is running.
REQ-015 done  output  1  end-of-cycle indicator.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ENTRY, LOAD, RUN, PAUSE and DONE.
REQ-017 In IDLE or ENTRY, key_valid with key_code<=9 SHALL shift digits left one BCD digit, inserting key_code as units; the old hundreds digit is discarded; next state is ENTRY.
REQ-018 key_valid with key_code>9, or in any other state, SHALL be ignored.
REQ-019 ENTRY->LOAD SHALL occur on start when door_closed=1 and digits!=0; otherwise start SHALL be ignored.
REQ-020 LOAD SHALL last exactly one cycle with load=1, then go to RUN; load SHALL be 0 in all other states.
REQ-021 en SHALL equal tick while in RUN, and 0 otherwise (combinational from the state register and tick).
REQ-022 heat_on SHALL be 1 exactly while the state is RUN.
REQ-023 In RUN, zero=1 SHALL go to DONE on the next edge; this takes priority over stop and door opening.
REQ-024 In RUN, stop=1 or door_closed=0 SHALL go to PAUSE.
REQ-025 In PAUSE, stop SHALL go to IDLE and clear digits to 0.
REQ-026 In PAUSE, start with door_closed=1 and no stop SHALL return to RUN without reloading.
REQ-027 In ENTRY, stop SHALL go to IDLE and clear digits.
REQ-028 Whenever start and stop are high in the same cycle, stop SHALL win.
REQ-029 In DONE, done SHALL be 1 for exactly DONE_CYCLES cycles, then the FSM returns to IDLE with digits cleared; all inputs are ignored in DONE.
REQ-030 digits SHALL hold its value through LOAD, RUN and PAUSE.

Reset
REQ-031 clearn=0 SHALL immediately force state IDLE, digits=0, the done counter to 0, and load/en/heat_on/done to 0, independent of clk.
REQ-032 Reset asserted mid-RUN SHALL drop heat_on and en asynchronously.
REQ-033 The first state change after release SHALL occur on the first clk edge with clearn=1.

Structure
REQ-034 The state encoding and the BCD_MAX=9 constant SHALL live in the shared package timer_pkg.
REQ-035 The BCD digit shift register SHALL be the sub-module bcd_entry_reg (ports: clk, clearn, shift, clr, key_code, digits).
REQ-036 The done counter SHALL be sized $clog2(DONE_CYCLES+1).

Verification
REQ-037 Keys 1,2,0 -> digits=0x120 and state ENTRY; then key 0xB -> digits unchanged.
REQ-038 digits=0x005, door closed, start -> load high for exactly one cycle, then RUN; 5 ticks -> en pulses 5 times, heat_on=1 throughout.
REQ-039 In RUN, door_closed to 0 -> PAUSE and heat_on=0; door closed plus start -> RUN resumes and load stays 0.
REQ-040 zero=1 in RUN in the same cycle as stop -> DONE; done high for 8 cycles, then IDLE with digits=0.
REQ-041 Keys 9,9,9,1 -> digits=0x991; start and stop together in ENTRY -> IDLE with digits=0.
REQ-042 clearn pulsed low mid-RUN between clk edges -> heat_on and en fall immediately, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the cooking-timer load controller.
package timer_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Largest key code that is a decimal digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when a key code is a decimal digit
    function automatic logic is_digit(input logic [3:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Three-digit BCD entry register: new digits shift in as units.
module bcd_entry_reg (
    input  logic        clk,
    input  logic        clearn,
    input  logic        shift,
    input  logic        clr,
    input  logic [3:0]  key_code,
    output logic [11:0] digits
);

    // Clear wins over shift; the old hundreds digit falls off the top
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn)
            digits <= 12'h000;
        else if (clr)
            digits <= 12'h000;
        else if (shift)
            digits <= {digits[7:0], key_code};
    end

endmodule

// File: rtl/timer_load_ctrl.sv
// Keypad entry / load / run / pause / done sequencer for a BCD down-counter.
module timer_load_ctrl
    import timer_pkg::*;
#(
    parameter int DONE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        clearn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic        tick,
    input  logic        zero,
    output logic [11:0] digits,
    output logic        load,
    output logic        en,
    output logic        heat_on,
    output logic        done
);

    localparam int             CW       = $clog2(DONE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DONE_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] done_cnt;
    logic          shift, clr;
    logic          digits_nz;

    assign digits_nz = (digits != 12'h000);

    bcd_entry_reg u_entry (
        .clk      (clk),
        .clearn   (clearn),
        .shift    (shift),
        .clr      (clr),
        .key_code (key_code),
        .digits   (digits)
    );

    // State register
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Counts cycles spent in DONE; idles at zero elsewhere
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn)
            done_cnt <= '0;
        else if (state == DONE && done_cnt != CNT_LAST)
            done_cnt <= done_cnt + 1'b1;
        else
            done_cnt <= '0;
    end

    // Next state plus the entry-register actions tied to each transition
    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid && is_digit(key_code)) begin
                    shift     = 1'b1;
                    state_nxt = ENTRY;
                end
            end
            ENTRY: begin
                // stop beats start, and a successful start freezes the entry
                if (stop) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end else if (start && door_closed && digits_nz) begin
                    state_nxt = LOAD;
                end else if (key_valid && is_digit(key_code)) begin
                    shift = 1'b1;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                // reaching zero outranks stop and door opening
                if (zero)
                    state_nxt = DONE;
                else if (stop || !door_closed)
                    state_nxt = PAUSE;
            end
            PAUSE: begin
                if (stop) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end else if (start && door_closed) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                if (done_cnt == CNT_LAST) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register (en also gated by tick)
    always_comb begin
        load    = (state == LOAD);
        heat_on = (state == RUN);
        en      = (state == RUN) && tick;
        done    = (state == DONE);
    end

endmodule

// File: tb/tb_timer_load_ctrl.sv
// Bench for timer_load_ctrl: vector table, directed corners, random vs model.
module tb_timer_load_ctrl;

    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        clearn;
    logic        kv, st, sp, dr, tk, zr;
    logic [3:0]  kc;
    logic [11:0] digits;
    logic        load, en, heat_on, done;

    int n_chk  = 0;
    int n_fail = 0;

    timer_load_ctrl #(.DONE_CYCLES(DC)) dut (
        .clk         (clk),
        .clearn      (clearn),
        .key_valid   (kv),
        .key_code    (kc),
        .start       (st),
        .stop        (sp),
        .door_closed (dr),
        .tick        (tk),
        .zero        (zr),
        .digits      (digits),
        .load        (load),
        .en          (en),
        .heat_on     (heat_on),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 entry, 2 load, 3 run, 4 pause, 5 done
    int m_mode, m_val, m_left;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] model_out();
        return {to_bcd(m_val), m_mode == 2, (m_mode == 3) && tk, m_mode == 3, m_mode == 5};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_val = 0; m_left = 0;
    endtask

    task automatic model_step();
        if (!clearn) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (kv && kc <= 9) begin m_val = (m_val * 10 + int'(kc)) % 1000; m_mode = 1; end
            1: begin
                if (sp) begin m_mode = 0; m_val = 0; end
                else if (st && dr && m_val != 0) m_mode = 2;
                else if (kv && kc <= 9) m_val = (m_val * 10 + int'(kc)) % 1000;
            end
            2: m_mode = 3;
            3: begin
                if (zr) begin m_mode = 5; m_left = DC; end
                else if (sp || !dr) m_mode = 4;
            end
            4: begin
                if (sp) begin m_mode = 0; m_val = 0; end
                else if (st && dr) m_mode = 3;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_val = 0; end
            end
        endcase
    endtask

    // ---------------- helpers ----------------
    function automatic logic [15:0] dut_out();
        return {digits, load, en, heat_on, done};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got dig=%h ld/en/ht/dn=%b expected dig=%h ld/en/ht/dn=%b",
                     name, act[15:4], act[3:0], exp[15:4], exp[3:0]);
        end
    endtask

    task automatic set_in(input logic a_kv, input logic [3:0] a_kc, input logic a_st,
                          input logic a_sp, input logic a_dr, input logic a_tk, input logic a_zr);
        @(negedge clk);
        kv = a_kv; kc = a_kc; st = a_st; sp = a_sp; dr = a_dr; tk = a_tk; zr = a_zr;
        #1;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        st, sp, dr, tk, zr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic a_kv, input logic [3:0] a_kc, input logic a_st,
                                input logic a_sp, input logic a_dr, input logic a_tk,
                                input logic a_zr, input logic [11:0] e_dig, input logic [3:0] e_o);
        vec_t v;
        v.kv = a_kv; v.kc = a_kc; v.st = a_st; v.sp = a_sp; v.dr = a_dr; v.tk = a_tk; v.zr = a_zr;
        v.exp = {e_dig, e_o};
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // outputs given as {load, en, heat_on, done}
        add(1, 4'd1, 0, 0, 1, 0, 0, 12'h000, 4'b0000);
        add(1, 4'd2, 0, 0, 1, 0, 0, 12'h001, 4'b0000);
        add(1, 4'd0, 0, 0, 1, 0, 0, 12'h012, 4'b0000);
        add(1, 4'hB, 0, 0, 1, 0, 0, 12'h120, 4'b0000);
        add(0, 4'd0, 0, 0, 1, 0, 0, 12'h120, 4'b0000);
        add(0, 4'd0, 0, 1, 1, 0, 0, 12'h120, 4'b0000);
        add(0, 4'd0, 0, 0, 1, 0, 0, 12'h000, 4'b0000);
        add(1, 4'd5, 0, 0, 1, 0, 0, 12'h000, 4'b0000);
        add(0, 4'd0, 1, 0, 0, 0, 0, 12'h005, 4'b0000);
        add(0, 4'd0, 0, 0, 1, 0, 0, 12'h005, 4'b0000);
        add(0, 4'd0, 1, 0, 1, 0, 0, 12'h005, 4'b0000);
        add(0, 4'd0, 0, 0, 1, 0, 0, 12'h005, 4'b1000);
        for (int i = 0; i < 5; i++)
            add(0, 4'd0, 0, 0, 1, 1, 0, 12'h005, 4'b0110);
        add(1, 4'd7, 0, 0, 1, 0, 0, 12'h005, 4'b0010);
        add(0, 4'd0, 0, 0, 0, 0, 0, 12'h005, 4'b0010);
        add(0, 4'd0, 1, 0, 1, 0, 0, 12'h005, 4'b0000);
        add(0, 4'd0, 0, 0, 1, 1, 0, 12'h005, 4'b0110);
        add(0, 4'd0, 0, 1, 1, 0, 1, 12'h005, 4'b0010);
        for (int i = 0; i < DC; i++)
            add(0, 4'd0, 0, 0, 1, 0, 0, 12'h005, 4'b0001);
        add(0, 4'd0, 0, 0, 1, 0, 0, 12'h000, 4'b0000);

        // reset state
        clearn = 1'b0;
        kv = 0; kc = 0; st = 0; sp = 0; dr = 0; tk = 0; zr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", dut_out(), 16'h0000);
        @(negedge clk);
        clearn = 1'b1;

        // table
        foreach (tbl[i]) begin
            set_in(tbl[i].kv, tbl[i].kc, tbl[i].st, tbl[i].sp, tbl[i].dr, tbl[i].tk, tbl[i].zr);
            chk($sformatf("table_row%0d", i), dut_out(), tbl[i].exp);
            clk_edge();
        end

        // keys 9,9,9,1 then start+stop together in ENTRY
        set_in(1, 4'd9, 0, 0, 1, 0, 0); clk_edge();
        set_in(1, 4'd9, 0, 0, 1, 0, 0); clk_edge();
        set_in(1, 4'd9, 0, 0, 1, 0, 0); clk_edge();
        set_in(1, 4'd1, 0, 0, 1, 0, 0); clk_edge();
        set_in(0, 4'd0, 1, 1, 1, 0, 0);
        chk("entry_991", dut_out(), {12'h991, 4'b0000});
        clk_edge();
        set_in(0, 4'd0, 1, 0, 1, 0, 0);
        chk("startstop_idle", dut_out(), 16'h0000);
        clk_edge();
        set_in(0, 4'd0, 0, 0, 1, 0, 0);
        chk("idle_ignores_start", dut_out(), 16'h0000);
        clk_edge();

        // async reset mid-RUN between edges
        set_in(1, 4'd3, 0, 0, 1, 0, 0); clk_edge();
        set_in(0, 4'd0, 1, 0, 1, 0, 0); clk_edge();
        set_in(0, 4'd0, 0, 0, 1, 0, 0);
        chk("load_pulse", dut_out(), {12'h003, 4'b1000});
        clk_edge();
        set_in(0, 4'd0, 0, 0, 1, 1, 0);
        chk("run_before_reset", dut_out(), {12'h003, 4'b0110});
        #1 clearn = 1'b0;
        #1 chk("async_reset_drop", dut_out(), 16'h0000);
        model_reset();
        @(posedge clk);
        #2 clearn = 1'b1;
        set_in(0, 4'd0, 0, 0, 1, 1, 0);
        chk("after_release_idle", dut_out(), 16'h0000);
        clk_edge();
        set_in(1, 4'd4, 0, 0, 1, 0, 0); clk_edge();
        set_in(0, 4'd0, 0, 0, 1, 0, 0);
        chk("after_release_key", dut_out(), {12'h004, 4'b0000});
        clk_edge();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                   $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 30,
                   $urandom_range(0, 99) < 4);
            chk($sformatf("random_cyc%0d", i), dut_out(), model_out());
            clk_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
